// File: rtl/hazard_unit_nlane_if.sv
// Issue/forwarding/flush bundle between the pipeline and hazard_unit_nlane.
// Lane-indexed fields are packed with lane 0 in the least-significant slice.
interface hazard_unit_nlane_if #(
  parameter int unsigned LANES = 2,
  parameter int unsigned REG_W = 5,
  parameter int unsigned FW_W  = $clog2(3 * LANES + 1)
);
  logic [LANES-1:0]       iss_valid;
  logic [LANES*REG_W-1:0] iss_rs1;
  logic [LANES*REG_W-1:0] iss_rs2;
  logic [LANES*REG_W-1:0] iss_rd;
  logic [LANES-1:0]       iss_we;
  logic [LANES-1:0]       iss_load;
  logic [LANES-1:0]       iss_store;
  logic [LANES-1:0]       iss_branch;
  logic [LANES*REG_W-1:0] ex_rd;
  logic [LANES*REG_W-1:0] mem_rd;
  logic [LANES*REG_W-1:0] wb_rd;
  logic [LANES-1:0]       ex_we;
  logic [LANES-1:0]       mem_we;
  logic [LANES-1:0]       wb_we;
  logic                   br_mispredict;
  logic [LANES-1:0]       iss_grant;
  logic [LANES*FW_W-1:0]  fwd_rs1;
  logic [LANES*FW_W-1:0]  fwd_rs2;
  logic                   stall_fetch;
  logic                   stall_dec;
  logic                   flush_dec;
  logic                   flush_iss;
  logic [31:0]            stall_count;

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_we, iss_load, iss_store, iss_branch,
    output ex_rd, mem_rd, wb_rd, ex_we, mem_we, wb_we, br_mispredict,
    input  iss_grant, fwd_rs1, fwd_rs2, stall_fetch, stall_dec, flush_dec, flush_iss,
    input  stall_count
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_we, iss_load, iss_store, iss_branch,
    input  ex_rd, mem_rd, wb_rd, ex_we, mem_we, wb_we, br_mispredict,
    output iss_grant, fwd_rs1, fwd_rs2, stall_fetch, stall_dec, flush_dec, flush_iss,
    output stall_count
  );
endinterface

// File: rtl/hazard_unit_nlane.sv
// N-lane in-order issue control: program-order grants, operand forwarding selects,
// load-use scoreboard, mispredict flush sequencing and a saturating stall counter.
module hazard_unit_nlane #(
  parameter int unsigned LANES        = 2,
  parameter int unsigned REG_W        = 5,
  parameter int unsigned MEM_PORTS    = 1,
  parameter int unsigned BR_UNITS     = 1,
  parameter int unsigned LOAD_USE     = 1,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned FW_W         = $clog2(3 * LANES + 1)
) (
  input logic clk,
  input logic rst,
  hazard_unit_nlane_if.slave bus
);
  localparam int unsigned NREGS = 1 << REG_W;
  localparam int unsigned SB_W  = $clog2(LOAD_USE + 2);
  localparam int unsigned FC_W  = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e                state_q;
  logic [FC_W-1:0]       fc_q;
  logic [SB_W-1:0]       sb_q [NREGS];
  logic [31:0]           stall_count_q;
  logic [NREGS-1:0]      sb_set;
  logic [LANES-1:0]      grant;
  logic                  flush;
  logic                  stall;
  logic [LANES*REG_W-1:0] st_rd [3];
  logic [LANES-1:0]       st_we [3];

  assign st_rd[0] = bus.ex_rd;
  assign st_rd[1] = bus.mem_rd;
  assign st_rd[2] = bus.wb_rd;
  assign st_we[0] = bus.ex_we;
  assign st_we[1] = bus.mem_we;
  assign st_we[2] = bus.wb_we;

  // Scan oldest stage/lowest lane first so the last match (Ex, youngest lane) wins.
  function automatic logic [FW_W-1:0] fwd_sel(input logic [REG_W-1:0] rs);
    logic [FW_W-1:0] sel;
    sel = '0;
    if (rs != '0) begin
      for (int s = 2; s >= 0; s--) begin
        for (int p = 0; p < int'(LANES); p++) begin
          if (st_we[s][p] && st_rd[s][p*REG_W +: REG_W] == rs) begin
            sel = FW_W'(1 + s * int'(LANES) + p);
          end
        end
      end
    end
    return sel;
  endfunction

  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      bus.fwd_rs1[l*FW_W +: FW_W] = fwd_sel(bus.iss_rs1[l*REG_W +: REG_W]);
      bus.fwd_rs2[l*FW_W +: FW_W] = fwd_sel(bus.iss_rs2[l*REG_W +: REG_W]);
    end
  end

  assign flush = (state_q == StFlush) || bus.br_mispredict;

  always_comb begin
    logic              ok;
    logic              raw;
    logic              sb_busy;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rdj;
    int unsigned       mem_cnt;
    int unsigned       br_cnt;
    grant   = '0;
    ok      = (state_q == StIdle) && !flush;
    raw     = 1'b0;
    sb_busy = 1'b0;
    rs1     = '0;
    rs2     = '0;
    rdj     = '0;
    mem_cnt = 0;
    br_cnt  = 0;
    for (int i = 0; i < int'(LANES); i++) begin
      rs1 = bus.iss_rs1[i*REG_W +: REG_W];
      rs2 = bus.iss_rs2[i*REG_W +: REG_W];
      if (bus.iss_load[i] || bus.iss_store[i]) mem_cnt++;
      if (bus.iss_branch[i]) br_cnt++;
      raw = 1'b0;
      for (int j = 0; j < i; j++) begin
        rdj = bus.iss_rd[j*REG_W +: REG_W];
        if (bus.iss_we[j] && rdj != '0 && (rdj == rs1 || rdj == rs2)) raw = 1'b1;
      end
      sb_busy = (rs1 != '0 && sb_q[rs1] != '0) || (rs2 != '0 && sb_q[rs2] != '0);
      ok = ok && bus.iss_valid[i] && !raw && !sb_busy &&
           (mem_cnt <= MEM_PORTS) && (br_cnt <= BR_UNITS);
      grant[i] = ok;
    end
  end

  assign stall = (state_q == StIdle) && !flush && ((bus.iss_valid & ~grant) != '0);

  always_comb begin
    sb_set = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (grant[i] && bus.iss_load[i] && bus.iss_we[i] &&
          bus.iss_rd[i*REG_W +: REG_W] != '0) begin
        sb_set[bus.iss_rd[i*REG_W +: REG_W]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      fc_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.br_mispredict) begin
            state_q <= StFlush;
            fc_q    <= FC_W'(FLUSH_CYCLES - 1);
          end
        end
        StFlush: begin
          if (bus.br_mispredict) begin
            fc_q <= FC_W'(FLUSH_CYCLES - 1);
          end else if (fc_q == '0) begin
            state_q <= StIdle;
          end else begin
            fc_q <= fc_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Register 0 is never set, so its counter stays at its reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(NREGS); r++) sb_q[r] <= '0;
    end else begin
      for (int r = 1; r < int'(NREGS); r++) begin
        if (sb_set[r]) begin
          sb_q[r] <= SB_W'(LOAD_USE + 1);
        end else if (sb_q[r] != '0) begin
          sb_q[r] <= sb_q[r] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
    end else if (stall && stall_count_q != 32'hFFFF_FFFF) begin
      stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign bus.iss_grant   = grant;
  assign bus.stall_fetch = stall;
  assign bus.stall_dec   = stall;
  assign bus.flush_dec   = flush;
  assign bus.flush_iss   = flush;
  assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_hazard_unit_nlane.sv
// Directed bench for hazard_unit_nlane (LANES=2): vector table for the combinational
// grant/forwarding paths, then hand sequences for load-use, flush, saturation and reset.
module tb_hazard_unit_nlane;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   stall_tally;

  hazard_unit_nlane_if #(.LANES(2), .REG_W(5)) bus ();

  hazard_unit_nlane #(.LANES(2), .REG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] valid, we, load, store, branch;
    logic [9:0] rs1, rs2, rd;
    logic [9:0] ex_rd, mem_rd, wb_rd;
    logic [1:0] ex_we, mem_we, wb_we;
    logic [1:0] exp_grant;
    logic [5:0] exp_f1, exp_f2;
    logic       exp_stall;
  } vec_t;

  vec_t vecs [15];

  // Lane-packing helpers: first argument is lane 1, second is lane 0.
  function automatic logic [9:0] r2(input int l1, input int l0);
    return {5'(l1), 5'(l0)};
  endfunction

  function automatic logic [5:0] f2(input int l1, input int l0);
    return {3'(l1), 3'(l0)};
  endfunction

  function automatic vec_t mk(
    input logic [1:0] valid, we, load, store, branch,
    input logic [9:0] rs1, rs2, rd,
    input logic [9:0] ex_rd, input logic [1:0] ex_we,
    input logic [9:0] mem_rd, input logic [1:0] mem_we,
    input logic [9:0] wb_rd, input logic [1:0] wb_we,
    input logic [1:0] g, input logic [5:0] f1, input logic [5:0] fr2, input logic st);
    vec_t v;
    v.valid = valid; v.we = we; v.load = load; v.store = store; v.branch = branch;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.ex_rd = ex_rd; v.ex_we = ex_we; v.mem_rd = mem_rd; v.mem_we = mem_we;
    v.wb_rd = wb_rd; v.wb_we = wb_we;
    v.exp_grant = g; v.exp_f1 = f1; v.exp_f2 = fr2; v.exp_stall = st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.iss_valid = '0; bus.iss_rs1 = '0; bus.iss_rs2 = '0; bus.iss_rd = '0;
    bus.iss_we = '0; bus.iss_load = '0; bus.iss_store = '0; bus.iss_branch = '0;
    bus.ex_rd = '0; bus.mem_rd = '0; bus.wb_rd = '0;
    bus.ex_we = '0; bus.mem_we = '0; bus.wb_we = '0;
    bus.br_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Two independent lanes that issue together when nothing blocks them.
  task automatic simple_bundle();
    clear_inputs();
    bus.iss_valid = 2'b11;
    bus.iss_rs1   = r2(2, 1);
    bus.iss_rd    = r2(11, 10);
    bus.iss_we    = 2'b11;
  endtask

  // Lane 1 reads lane 0's destination: grants 01 and stalls when idle.
  task automatic raw_bundle();
    clear_inputs();
    bus.iss_valid = 2'b11;
    bus.iss_rd    = r2(0, 3);
    bus.iss_we    = 2'b01;
    bus.iss_rs1   = r2(3, 0);
  endtask

  task automatic chk_flush(input string nm, input logic exp);
    chk({nm, "_flush_dec"}, 64'(bus.flush_dec), 64'(exp));
    chk({nm, "_flush_iss"}, 64'(bus.flush_iss), 64'(exp));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    stall_tally = 0;
    rst = 1'b1;
    clear_inputs();

    //          valid  we     load   store  branch rs1        rs2        rd
    //          ex_rd      ex_we  mem_rd     mem_we wb_rd       wb_we  grant f1  f2  stall
    vecs[0]  = mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, r2(5, 0), r2(0, 0), r2(0, 0),
                  r2(0, 5), 2'b01, r2(5, 0), 2'b10, r2(0, 0), 2'b00, 2'b11, f2(1, 0), f2(0, 0), 0);
    vecs[1]  = mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, r2(5, 0), r2(0, 0), r2(0, 0),
                  r2(0, 5), 2'b00, r2(5, 0), 2'b10, r2(0, 0), 2'b00, 2'b11, f2(4, 0), f2(0, 0), 0);
    vecs[2]  = mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, r2(0, 9), r2(9, 0), r2(0, 0),
                  r2(9, 9), 2'b11, r2(0, 0), 2'b00, r2(0, 0), 2'b11, 2'b11, f2(0, 2), f2(2, 0), 0);
    vecs[3]  = mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, r2(12, 0), r2(0, 12), r2(0, 0),
                  r2(0, 0), 2'b00, r2(0, 12), 2'b00, r2(12, 12), 2'b11, 2'b11, f2(6, 0), f2(0, 6), 0);
    vecs[4]  = mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, r2(0, 20), r2(0, 0), r2(0, 0),
                  r2(0, 0), 2'b00, r2(0, 20), 2'b01, r2(20, 0), 2'b10, 2'b11, f2(0, 3), f2(0, 0), 0);
    vecs[5]  = mk(2'b11, 2'b01, 2'b00, 2'b00, 2'b00, r2(3, 0), r2(0, 0), r2(0, 3),
                  r2(0, 0), 2'b00, r2(0, 0), 2'b00, r2(0, 0), 2'b00, 2'b01, f2(0, 0), f2(0, 0), 1);
    vecs[6]  = mk(2'b11, 2'b01, 2'b00, 2'b00, 2'b00, r2(3, 0), r2(0, 0), r2(0, 0),
                  r2(0, 0), 2'b00, r2(0, 0), 2'b00, r2(0, 0), 2'b00, 2'b11, f2(0, 0), f2(0, 0), 0);
    vecs[7]  = mk(2'b11, 2'b01, 2'b00, 2'b00, 2'b00, r2(0, 0), r2(8, 0), r2(0, 8),
                  r2(0, 0), 2'b00, r2(0, 0), 2'b00, r2(0, 0), 2'b00, 2'b01, f2(0, 0), f2(0, 0), 1);
    vecs[8]  = mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, r2(0, 0), r2(8, 0), r2(0, 8),
                  r2(0, 0), 2'b00, r2(0, 0), 2'b00, r2(0, 0), 2'b00, 2'b11, f2(0, 0), f2(0, 0), 0);
    vecs[9]  = mk(2'b11, 2'b00, 2'b10, 2'b01, 2'b00, r2(0, 0), r2(0, 0), r2(0, 0),
                  r2(0, 0), 2'b00, r2(0, 0), 2'b00, r2(0, 0), 2'b00, 2'b01, f2(0, 0), f2(0, 0), 1);
    vecs[10] = mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, r2(0, 0), r2(0, 0), r2(0, 0),
                  r2(0, 0), 2'b00, r2(0, 0), 2'b00, r2(0, 0), 2'b00, 2'b01, f2(0, 0), f2(0, 0), 1);
    vecs[11] = mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, r2(0, 0), r2(0, 0), r2(0, 0),
                  r2(0, 0), 2'b00, r2(0, 0), 2'b00, r2(0, 0), 2'b00, 2'b00, f2(0, 0), f2(0, 0), 1);
    vecs[12] = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, r2(0, 0), r2(0, 0), r2(0, 0),
                  r2(0, 0), 2'b00, r2(0, 0), 2'b00, r2(0, 0), 2'b00, 2'b00, f2(0, 0), f2(0, 0), 0);
    vecs[13] = mk(2'b11, 2'b00, 2'b00, 2'b01, 2'b10, r2(0, 0), r2(0, 0), r2(0, 0),
                  r2(0, 0), 2'b00, r2(0, 0), 2'b00, r2(0, 0), 2'b00, 2'b11, f2(0, 0), f2(0, 0), 0);
    vecs[14] = mk(2'b11, 2'b11, 2'b00, 2'b00, 2'b00, r2(0, 0), r2(0, 0), r2(4, 4),
                  r2(0, 0), 2'b00, r2(0, 0), 2'b00, r2(0, 0), 2'b00, 2'b11, f2(0, 0), f2(0, 0), 0);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_grant", 64'(bus.iss_grant), 64'd0);
    chk("rst_fwd", 64'({bus.fwd_rs1, bus.fwd_rs2}), 64'd0);
    chk("rst_stall", 64'({bus.stall_fetch, bus.stall_dec}), 64'd0);
    chk_flush("rst", 1'b0);
    chk("rst_count", 64'(bus.stall_count), 64'd0);

    // Vector table: one vector per cycle, each held across one rising edge.
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      bus.iss_valid = vecs[k].valid; bus.iss_we = vecs[k].we;
      bus.iss_load = vecs[k].load; bus.iss_store = vecs[k].store;
      bus.iss_branch = vecs[k].branch;
      bus.iss_rs1 = vecs[k].rs1; bus.iss_rs2 = vecs[k].rs2; bus.iss_rd = vecs[k].rd;
      bus.ex_rd = vecs[k].ex_rd; bus.ex_we = vecs[k].ex_we;
      bus.mem_rd = vecs[k].mem_rd; bus.mem_we = vecs[k].mem_we;
      bus.wb_rd = vecs[k].wb_rd; bus.wb_we = vecs[k].wb_we;
      if (vecs[k].exp_stall) stall_tally++;
      #1;
      chk($sformatf("vec%0d_grant", k), 64'(bus.iss_grant), 64'(vecs[k].exp_grant));
      chk($sformatf("vec%0d_fwd1", k), 64'(bus.fwd_rs1), 64'(vecs[k].exp_f1));
      chk($sformatf("vec%0d_fwd2", k), 64'(bus.fwd_rs2), 64'(vecs[k].exp_f2));
      chk($sformatf("vec%0d_stall_fetch", k), 64'(bus.stall_fetch), 64'(vecs[k].exp_stall));
      chk($sformatf("vec%0d_stall_dec", k), 64'(bus.stall_dec), 64'(vecs[k].exp_stall));
      chk($sformatf("vec%0d_flush", k), 64'(bus.flush_dec), 64'd0);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    chk("table_stall_count", 64'(bus.stall_count), 64'(stall_tally));

    // Load-use: two stalled cycles, then the consumer issues.
    do_reset();
    bus.iss_valid = 2'b01; bus.iss_load = 2'b01; bus.iss_we = 2'b01; bus.iss_rd = r2(0, 7);
    #1;
    chk("lu_load_grant", 64'(bus.iss_grant), 64'b01);
    @(negedge clk);
    clear_inputs();
    bus.iss_valid = 2'b01; bus.iss_rs2 = r2(0, 7); bus.iss_rd = r2(0, 9); bus.iss_we = 2'b01;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("lu_stall%0d_grant", c), 64'(bus.iss_grant), 64'b00);
      chk($sformatf("lu_stall%0d_stall", c), 64'(bus.stall_fetch), 64'd1);
      @(negedge clk);
    end
    #1;
    chk("lu_issue_grant", 64'(bus.iss_grant), 64'b01);
    chk("lu_issue_stall", 64'(bus.stall_fetch), 64'd0);
    chk("lu_stall_count", 64'(bus.stall_count), 64'd2);

    // Memory-port limit, then the leftover load re-presented alone.
    @(negedge clk);
    clear_inputs();
    bus.iss_valid = 2'b11; bus.iss_store = 2'b01; bus.iss_load = 2'b10;
    bus.iss_we = 2'b10; bus.iss_rd = r2(14, 0);
    #1;
    chk("mp_pair_grant", 64'(bus.iss_grant), 64'b01);
    chk("mp_pair_stall", 64'(bus.stall_fetch), 64'd1);
    @(negedge clk);
    clear_inputs();
    bus.iss_valid = 2'b01; bus.iss_load = 2'b01; bus.iss_we = 2'b01; bus.iss_rd = r2(0, 14);
    #1;
    chk("mp_single_grant", 64'(bus.iss_grant), 64'b01);
    chk("mp_single_stall", 64'(bus.stall_fetch), 64'd0);

    // Single mispredict: flush for three cycles, then normal issue.
    do_reset();
    simple_bundle();
    bus.br_mispredict = 1'b1;
    #1;
    chk_flush("f1_t0", 1'b1);
    chk("f1_t0_grant", 64'(bus.iss_grant), 64'b00);
    chk("f1_t0_stall", 64'(bus.stall_fetch), 64'd0);
    @(negedge clk);
    bus.br_mispredict = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      #1;
      chk_flush($sformatf("f1_t%0d", c), 1'b1);
      chk($sformatf("f1_t%0d_grant", c), 64'(bus.iss_grant), 64'b00);
      @(negedge clk);
    end
    #1;
    chk_flush("f1_t3", 1'b0);
    chk("f1_t3_grant", 64'(bus.iss_grant), 64'b11);

    // Second pulse during flush extends it; flush masks the RAW stall.
    @(negedge clk);
    raw_bundle();
    bus.br_mispredict = 1'b1;
    @(negedge clk);
    #1;
    chk_flush("f2_t1", 1'b1);
    @(negedge clk);
    bus.br_mispredict = 1'b0;
    for (int c = 2; c <= 3; c++) begin
      #1;
      chk_flush($sformatf("f2_t%0d", c), 1'b1);
      chk($sformatf("f2_t%0d_stall", c), 64'(bus.stall_dec), 64'd0);
      chk($sformatf("f2_t%0d_grant", c), 64'(bus.iss_grant), 64'b00);
      @(negedge clk);
    end
    #1;
    chk_flush("f2_t4", 1'b0);
    chk("f2_t4_grant", 64'(bus.iss_grant), 64'b01);
    chk("f2_t4_stall", 64'(bus.stall_dec), 64'd1);

    // Reset in the middle of a flush leaves no residual flush.
    @(negedge clk);
    simple_bundle();
    bus.br_mispredict = 1'b1;
    @(negedge clk);
    bus.br_mispredict = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_flush("rstf", 1'b0);
    chk("rstf_grant", 64'(bus.iss_grant), 64'b11);

    // Saturation: preload the counter near its maximum while stalling.
    @(negedge clk);
    clear_inputs();
    bus.iss_valid = 2'b10;
    force dut.stall_count_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_count_q;
    @(negedge clk);
    #1;
    chk("sat_step", 64'(bus.stall_count), 64'hFFFF_FFFE);
    repeat (4) @(negedge clk);
    #1;
    chk("sat_hold", 64'(bus.stall_count), 64'hFFFF_FFFF);

    // A granted load then reset: scoreboard and counter both cleared.
    @(negedge clk);
    clear_inputs();
    bus.iss_valid = 2'b01; bus.iss_load = 2'b01; bus.iss_we = 2'b01; bus.iss_rd = r2(0, 7);
    #1;
    chk("rsb_load_grant", 64'(bus.iss_grant), 64'b01);
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.iss_valid = 2'b01; bus.iss_rs1 = r2(0, 7);
    #1;
    chk("rsb_grant", 64'(bus.iss_grant), 64'b01);
    chk("rsb_count", 64'(bus.stall_count), 64'd0);
    chk_flush("rsb", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
